// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit (master) and imem (slave).
// Request is held stable until imem_ready; the response is valid only in the cycle imem_ready is high.
`timescale 1ns/1ps
interface fetch_unit_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;

   modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
   modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);
endinterface

// File: rtl/fetch_unit.sv
// IF stage: PC, imem request and IF/ID register; one cycle from imem_ready to IF_ID_valid.
// pc_write/IF_ID_write stalls park the returned word in a hold buffer and drop imem_req until released.
`timescale 1ns/1ps
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               pc_write,
   input  logic               IF_ID_write,
   input  logic               branch_taken,
   input  logic [31:0]        branch_target,
   fetch_unit_if.master       imem,
   output logic [31:0]        IF_ID_pc,
   output logic [31:0]        IF_ID_instr,
   output logic               IF_ID_valid,
   output logic               fetch_busy,
   output logic [15:0]        stall_count
);

   localparam logic [0:0] FETCH = 1'b0;
   localparam logic [0:0] HOLD  = 1'b1;

   logic [0:0]  state;
   logic [31:0] pc;
   logic [31:0] pc_inc;
   logic [31:0] target;
   logic [31:0] redirect_pc;
   logic        redirect_pending;
   logic [31:0] hold_buf;
   logic        advance;
   logic        unused_target_lsb;

   assign pc_inc            = pc + 32'd4;
   assign target            = {branch_target[31:2], 2'b00};
   assign unused_target_lsb = ^branch_target[1:0];
   assign advance           = pc_write & IF_ID_write;

   assign imem.imem_req  = (state == FETCH);
   assign imem.imem_addr = pc;
   assign fetch_busy     = (state == FETCH) & ~imem.imem_ready;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state            <= FETCH;
         pc               <= RESET_PC;
         redirect_pc      <= 32'd0;
         redirect_pending <= 1'b0;
         hold_buf         <= 32'd0;
         IF_ID_pc         <= 32'd0;
         IF_ID_instr      <= 32'd0;
         IF_ID_valid      <= 1'b0;
         stall_count      <= 16'd0;
      end else begin
         if (!pc_write && stall_count != 16'hFFFF)
            stall_count <= stall_count + 16'd1;

         case (state)
            FETCH: begin
               if (imem.imem_ready) begin
                  // A fresh branch outranks an older pending redirect: latest target wins.
                  if (branch_taken) begin
                     pc               <= target;
                     redirect_pending <= 1'b0;
                     IF_ID_valid      <= 1'b0;
                  end else if (redirect_pending) begin
                     pc               <= redirect_pc;
                     redirect_pending <= 1'b0;
                     if (IF_ID_write)
                        IF_ID_valid <= 1'b0;
                  end else if (advance) begin
                     IF_ID_pc    <= pc;
                     IF_ID_instr <= imem.imem_rdata;
                     IF_ID_valid <= 1'b1;
                     pc          <= pc_inc;
                  end else begin
                     hold_buf <= imem.imem_rdata;
                     state    <= HOLD;
                  end
               end else begin
                  // Address must stay put while the request is outstanding; park the redirect.
                  if (branch_taken) begin
                     redirect_pc      <= target;
                     redirect_pending <= 1'b1;
                     IF_ID_valid      <= 1'b0;
                  end else if (IF_ID_write) begin
                     IF_ID_valid <= 1'b0;
                  end
               end
            end
            HOLD: begin
               if (branch_taken) begin
                  pc          <= target;
                  IF_ID_valid <= 1'b0;
                  state       <= FETCH;
               end else if (advance) begin
                  IF_ID_pc    <= pc;
                  IF_ID_instr <= hold_buf;
                  IF_ID_valid <= 1'b1;
                  pc          <= pc_inc;
                  state       <= FETCH;
               end
            end
            default: state <= FETCH;
         endcase
      end
   end

endmodule
